instr_fetch_unit: RTL and testbench

Instruction fetch stage feeding the multi-cycle CPU control FSM: on a fetch request from the FSM's IFetch state it reads one instruction word from instruction memory over a req/ack handshake. It then presents the word, its PC and its 6-bit opcode to the FSM. It owns the program counter, advances it by one instruction per completed fetch, and applies branch/jump redirects from later stages.

---
 rtl/instr_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC and reads one word per fetch_start over a req/ack handshake.
// It holds the fetched word for the control FSM until instr_ready, and applies branch/jump redirects.
module instr_fetch_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_start,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_err,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic [5:0]        op,
   input  logic              instr_ready,
   output logic              fetch_busy,
   output logic              fetch_fault,
   output logic [15:0]       fetch_count,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2, FAULT = 2'd3} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                mem_req_q, mem_req_d;
   logic [DATA_W-1:0]   instr_q, instr_d;
   logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
   logic [5:0]          op_q, op_d;
   logic                instr_valid_q, instr_valid_d;
   logic                fetch_busy_q, fetch_busy_d;
   logic                fetch_fault_q, fetch_fault_d;
   logic [15:0]         fetch_count_q, fetch_count_d;
   logic                pend_q, pend_d;
   logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;

   // Handshakes: a memory read completes on a cycle where mem_req & mem_ack are both high,
   // and mem_addr stays constant for as long as mem_req is high. An instruction is handed
   // over on a cycle where instr_valid & instr_ready are both high.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      mem_addr_d    = mem_addr_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      op_d          = op_q;
      fetch_count_d = fetch_count_q;
      pend_d        = pend_q;
      pend_pc_d     = pend_pc_q;

      case (state_q)
         IDLE: begin
            if (redirect_valid) pc_d = redirect_pc;
            if (fetch_start) begin
               state_d    = REQ;
               mem_addr_d = redirect_valid ? redirect_pc : pc_q;
            end
         end
         REQ: begin
            if (redirect_valid) begin
               pend_d    = 1'b1;
               pend_pc_d = redirect_pc;
            end
            if (mem_ack) begin
               if (pend_q || redirect_valid) begin
                  // Wrong-path data: drop it and restart the handshake at the redirect target.
                  pc_d       = redirect_valid ? redirect_pc : pend_pc_q;
                  mem_addr_d = redirect_valid ? redirect_pc : pend_pc_q;
                  pend_d     = 1'b0;
               end else if (mem_err) begin
                  state_d = FAULT;
               end else begin
                  state_d    = HOLD;
                  instr_d    = mem_rdata;
                  instr_pc_d = mem_addr_q;
                  op_d       = mem_rdata[31:26];
                  pc_d       = pc_q + PC_STEP;
               end
            end
         end
         HOLD: begin
            if (redirect_valid) pc_d = redirect_pc;
            if (instr_ready) begin
               state_d       = IDLE;
               fetch_count_d = fetch_count_q + 16'd1;
            end
         end
         FAULT: begin
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      mem_req_d     = (state_d == REQ);
      instr_valid_d = (state_d == HOLD);
      fetch_busy_d  = (state_d != IDLE);
      fetch_fault_d = (state_d == FAULT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         mem_addr_q    <= RESET_PC;
         mem_req_q     <= 1'b0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         op_q          <= '0;
         instr_valid_q <= 1'b0;
         fetch_busy_q  <= 1'b0;
         fetch_fault_q <= 1'b0;
         fetch_count_q <= '0;
         pend_q        <= 1'b0;
         pend_pc_q     <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         mem_addr_q    <= mem_addr_d;
         mem_req_q     <= mem_req_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         op_q          <= op_d;
         instr_valid_q <= instr_valid_d;
         fetch_busy_q  <= fetch_busy_d;
         fetch_fault_q <= fetch_fault_d;
         fetch_count_q <= fetch_count_d;
         pend_q        <= pend_d;
         pend_pc_q     <= pend_pc_d;
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign instr_valid = instr_valid_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign op          = op_q;
   assign fetch_busy  = fetch_busy_q;
   assign fetch_fault = fetch_fault_q;
   assign fetch_count = fetch_count_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one task per scenario, inline checks, one summary line.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   int          checks = 0;
   int          errors = 0;

   logic        fetch_start, redirect_valid, mem_ack, mem_err, instr_ready;
   logic [31:0] redirect_pc, mem_rdata;
   logic        mem_req, instr_valid, fetch_busy, fetch_fault;
   logic [31:0] mem_addr, instr, instr_pc;
   logic [5:0]  op;
   logic [15:0] fetch_count;
   logic [1:0]  dbg_state;

   logic        b_fetch_start, b_mem_ack, b_instr_ready;
   logic [31:0] b_mem_rdata;
   logic        b_mem_req, b_instr_valid, b_fetch_busy, b_fetch_fault;
   logic [31:0] b_mem_addr, b_instr, b_instr_pc;
   logic [5:0]  b_op;
   logic [15:0] b_fetch_count;
   logic [1:0]  b_dbg_state;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk(clk), .reset(reset), .fetch_start(fetch_start),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .mem_err(mem_err), .instr_valid(instr_valid),
      .instr(instr), .instr_pc(instr_pc), .op(op), .instr_ready(instr_ready),
      .fetch_busy(fetch_busy), .fetch_fault(fetch_fault),
      .fetch_count(fetch_count), .dbg_state(dbg_state)
   );

   instr_fetch_unit #(.RESET_PC(32'h100)) dut_b (
      .clk(clk), .reset(reset), .fetch_start(b_fetch_start),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_ack(b_mem_ack),
      .mem_rdata(b_mem_rdata), .mem_err(1'b0), .instr_valid(b_instr_valid),
      .instr(b_instr), .instr_pc(b_instr_pc), .op(b_op), .instr_ready(b_instr_ready),
      .fetch_busy(b_fetch_busy), .fetch_fault(b_fetch_fault),
      .fetch_count(b_fetch_count), .dbg_state(b_dbg_state)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect_idle(input logic [31:0] target);
      redirect_valid = 1'b1; redirect_pc = target;
      cyc();
      redirect_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
      checks++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0 ||
          instr_pc !== 32'h0 || op !== 6'h0 || fetch_busy !== 1'b0 || fetch_fault !== 1'b0 ||
          fetch_count !== 16'h0 || dut.pc_q !== 32'h0) begin
         errors++;
         $display("FAIL reset_a: req=%b addr=%h valid=%b instr=%h ipc=%h op=%h busy=%b fault=%b cnt=%0d pc=%h, required all zero",
                  mem_req, mem_addr, instr_valid, instr, instr_pc, op, fetch_busy, fetch_fault, fetch_count, dut.pc_q);
      end
      checks++;
      if (b_mem_req !== 1'b0 || b_mem_addr !== 32'h100 || b_instr_valid !== 1'b0 || b_fetch_count !== 16'h0) begin
         errors++;
         $display("FAIL reset_b: req=%b addr=%h valid=%b cnt=%0d, required 0 100 0 0",
                  b_mem_req, b_mem_addr, b_instr_valid, b_fetch_count);
      end
   endtask

   task automatic test_basic_fetch();
      fetch_start = 1'b1;
      cyc();
      fetch_start = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0 || fetch_busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_req: req=%b addr=%h busy=%b, required 1 0 1", mem_req, mem_addr, fetch_busy);
      end
      mem_ack = 1'b1; mem_rdata = 32'h00221820;
      cyc();
      mem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b1 || mem_req !== 1'b0 || instr !== 32'h00221820 || op !== 6'h00 ||
          instr_pc !== 32'h0 || dut.pc_q !== 32'h4) begin
         errors++;
         $display("FAIL basic_data: valid=%b req=%b instr=%h op=%h ipc=%h pc=%h, required 1 0 00221820 00 0 4",
                  instr_valid, mem_req, instr, op, instr_pc, dut.pc_q);
      end
      instr_ready = 1'b1;
      cyc();
      instr_ready = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || fetch_count !== 16'd1 || fetch_busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_consume: valid=%b cnt=%0d busy=%b, required 0 1 0", instr_valid, fetch_count, fetch_busy);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 3; k++) begin
         b_fetch_start = 1'b1;
         cyc();
         b_fetch_start = 1'b0;
         for (int j = 0; j < 3; j++) begin
            checks++;
            if (b_mem_req !== 1'b1 || b_mem_addr !== 32'h100 + 32'(4 * k)) begin
               errors++;
               $display("FAIL b2b_addr[%0d.%0d]: req=%b addr=%h, required 1 %h", k, j, b_mem_req, b_mem_addr, 32'h100 + 32'(4 * k));
            end
            if (j == 2) begin
               b_mem_ack = 1'b1; b_mem_rdata = {6'h23, 26'(k)};
            end
            cyc();
         end
         b_mem_ack = 1'b0;
         checks++;
         if (b_instr_valid !== 1'b1 || b_instr_pc !== 32'h100 + 32'(4 * k) || b_op !== 6'h23 ||
             b_instr !== {6'h23, 26'(k)}) begin
            errors++;
            $display("FAIL b2b_data[%0d]: valid=%b ipc=%h op=%h instr=%h", k, b_instr_valid, b_instr_pc, b_op, b_instr);
         end
         b_instr_ready = 1'b1;
         cyc();
         b_instr_ready = 1'b0;
      end
      checks++;
      if (b_fetch_count !== 16'd3 || b_instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_count: cnt=%0d valid=%b, required 3 0", b_fetch_count, b_instr_valid);
      end
   endtask

   task automatic test_redirect_req();
      redirect_idle(32'h8);
      checks++;
      if (dut.pc_q !== 32'h8 || fetch_busy !== 1'b0) begin
         errors++;
         $display("FAIL redir_idle: pc=%h busy=%b, required 8 0", dut.pc_q, fetch_busy);
      end
      fetch_start = 1'b1;
      cyc();
      fetch_start = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      cyc();
      redirect_valid = 1'b0;
      cyc();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
         errors++;
         $display("FAIL redir_hold_addr: req=%b addr=%h, required 1 8", mem_req, mem_addr);
      end
      mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      cyc();
      mem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h40 || dut.pc_q !== 32'h40) begin
         errors++;
         $display("FAIL redir_discard: valid=%b req=%b addr=%h pc=%h, required 0 1 40 40",
                  instr_valid, mem_req, mem_addr, dut.pc_q);
      end
      mem_ack = 1'b1; mem_rdata = 32'h8C430004;
      cyc();
      mem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || op !== 6'h23 || dut.pc_q !== 32'h44 ||
          fetch_count !== 16'd1) begin
         errors++;
         $display("FAIL redir_refetch: valid=%b ipc=%h op=%h pc=%h cnt=%0d, required 1 40 23 44 1",
                  instr_valid, instr_pc, op, dut.pc_q, fetch_count);
      end
      instr_ready = 1'b1;
      cyc();
      instr_ready = 1'b0;
   endtask

   task automatic test_redirect_same_cycle();
      fetch_start = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h20;
      cyc();
      fetch_start = 1'b0; redirect_valid = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
         errors++;
         $display("FAIL same_idle: req=%b addr=%h, required 1 20", mem_req, mem_addr);
      end
      redirect_valid = 1'b1; redirect_pc = 32'h60; mem_ack = 1'b1; mem_rdata = 32'h11111111;
      cyc();
      redirect_valid = 1'b0; mem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h60) begin
         errors++;
         $display("FAIL same_req_ack: valid=%b req=%b addr=%h, required 0 1 60", instr_valid, mem_req, mem_addr);
      end
      mem_ack = 1'b1; mem_rdata = 32'h08000010;
      cyc();
      mem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h60 || op !== 6'h02 || dut.pc_q !== 32'h64) begin
         errors++;
         $display("FAIL same_refetch: valid=%b ipc=%h op=%h pc=%h, required 1 60 02 64", instr_valid, instr_pc, op, dut.pc_q);
      end
      instr_ready = 1'b1;
      cyc();
      instr_ready = 1'b0;
      checks++;
      if (fetch_count !== 16'd3) begin
         errors++;
         $display("FAIL same_count: cnt=%0d, required 3", fetch_count);
      end
   endtask

   task automatic test_fault();
      redirect_idle(32'hC);
      fetch_start = 1'b1;
      cyc();
      fetch_start = 1'b0;
      mem_err = 1'b1;
      cyc();
      checks++;
      if (mem_req !== 1'b1 || fetch_fault !== 1'b0 || mem_addr !== 32'hC) begin
         errors++;
         $display("FAIL fault_err_no_ack: req=%b fault=%b addr=%h, required 1 0 c", mem_req, fetch_fault, mem_addr);
      end
      mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0; mem_err = 1'b0;
      checks++;
      if (fetch_fault !== 1'b1 || mem_req !== 1'b0 || instr_valid !== 1'b0 || dut.pc_q !== 32'hC || fetch_busy !== 1'b1) begin
         errors++;
         $display("FAIL fault_enter: fault=%b req=%b valid=%b pc=%h busy=%b, required 1 0 0 c 1",
                  fetch_fault, mem_req, instr_valid, dut.pc_q, fetch_busy);
      end
      fetch_start = 1'b1;
      cyc(); cyc();
      fetch_start = 1'b0;
      checks++;
      if (fetch_fault !== 1'b1 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL fault_sticky: fault=%b req=%b, required 1 0", fetch_fault, mem_req);
      end
      redirect_idle(32'h0);
      checks++;
      if (fetch_fault !== 1'b0 || fetch_busy !== 1'b0 || dut.pc_q !== 32'h0) begin
         errors++;
         $display("FAIL fault_clear: fault=%b busy=%b pc=%h, required 0 0 0", fetch_fault, fetch_busy, dut.pc_q);
      end
      fetch_start = 1'b1;
      cyc();
      fetch_start = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
         errors++;
         $display("FAIL fault_refetch: req=%b addr=%h, required 1 0", mem_req, mem_addr);
      end
      mem_ack = 1'b1; mem_rdata = 32'h00221820;
      cyc();
      mem_ack = 1'b0;
      instr_ready = 1'b1;
      cyc();
      instr_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      fetch_start = 1'b1;
      cyc();
      fetch_start = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h4 || fetch_count !== 16'd4) begin
         errors++;
         $display("FAIL rmid_pre: req=%b addr=%h cnt=%0d, required 1 4 4", mem_req, mem_addr, fetch_count);
      end
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      checks++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h0 || fetch_count !== 16'd0 || instr !== 32'h0 || fetch_busy !== 1'b0) begin
         errors++;
         $display("FAIL rmid_reset: req=%b addr=%h cnt=%0d instr=%h busy=%b, required 0 0 0 0 0",
                  mem_req, mem_addr, fetch_count, instr, fetch_busy);
      end
      cyc();
      mem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || mem_req !== 1'b0 || fetch_busy !== 1'b0 || fetch_count !== 16'd0 || dut.pc_q !== 32'h0) begin
         errors++;
         $display("FAIL rmid_late_ack: valid=%b req=%b busy=%b cnt=%0d pc=%h, required 0 0 0 0 0",
                  instr_valid, mem_req, fetch_busy, fetch_count, dut.pc_q);
      end
   endtask

   task automatic test_pc_wrap();
      redirect_idle(32'hFFFF_FFFC);
      fetch_start = 1'b1;
      cyc();
      fetch_start = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'hAC000000;
      cyc();
      mem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || op !== 6'h2B || dut.pc_q !== 32'h0) begin
         errors++;
         $display("FAIL wrap_data: valid=%b ipc=%h op=%h pc=%h, required 1 fffffffc 2b 0", instr_valid, instr_pc, op, dut.pc_q);
      end
      instr_ready = 1'b1;
      cyc();
      instr_ready = 1'b0;
      fetch_start = 1'b1;
      cyc();
      fetch_start = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0 || fetch_count !== 16'd1) begin
         errors++;
         $display("FAIL wrap_next: req=%b addr=%h cnt=%0d, required 1 0 1", mem_req, mem_addr, fetch_count);
      end
      mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
      instr_ready = 1'b1;
      cyc();
      instr_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      fetch_start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0; instr_ready = 1'b0;
      b_fetch_start = 1'b0; b_mem_ack = 1'b0; b_mem_rdata = '0; b_instr_ready = 1'b0;
      test_reset();
      test_basic_fetch();
      test_back_to_back();
      test_redirect_req();
      test_redirect_same_cycle();
      test_fault();
      test_reset_mid();
      test_pc_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
